// File: rtl/bf0_fetch_hazard.sv
// IF stage and IF/ID buffer with load-use stall/bubble and MEM-branch flush.
// Optional build macro BF0_STALL_COUNT_EN adds a saturating stall/flush counter port.
module bf0_fetch_hazard #(
    parameter int PC_W     = 8,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk_BF0,
    input  logic            rst_n_BF0,
    input  logic [31:0]     instr_IN,
    input  logic            hold_IN,
    input  logic            branch_taken_IN,
    input  logic [PC_W-1:0] branch_target_IN,
    input  logic            idex_memread_IN,
    input  logic [4:0]      idex_rt_IN,
    output logic [PC_W-1:0] pc_BF0,
    output logic [31:0]     instr_BF0,
    output logic [PC_W-1:0] nextInst_BF0,
    output logic            valid_BF0,
    output logic            bubble_BF0,
    output logic [1:0]      state_BF0
`ifdef BF0_STALL_COUNT_EN
    ,
    output logic [15:0]     stall_cnt_BF0
`endif
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [31:0]     r_instr, w_instr_next;
    logic [PC_W-1:0] r_next_inst, w_next_inst_next;
    logic            r_valid, w_valid_next;

    logic [PC_W-1:0] w_pc_inc;
    logic [5:0]      w_opcode;
    logic            w_uses_rt;
    logic            w_hazard;

    assign w_pc_inc = r_pc + PC_W'(PC_INC);
    assign w_opcode = r_instr[31:26];

    // Only these formats read rt as a source; lw and I-type ALU ops write it.
    always_comb begin
        w_uses_rt = 1'b0;
        case (w_opcode)
            6'h00, 6'h04, 6'h05, 6'h2B: w_uses_rt = 1'b1;
            default:                    w_uses_rt = 1'b0;
        endcase
    end

    assign w_hazard = r_valid & idex_memread_IN & (idex_rt_IN != 5'd0) &
                      ((idex_rt_IN == r_instr[25:21]) |
                       (w_uses_rt & (idex_rt_IN == r_instr[20:16])));

    assign bubble_BF0 = w_hazard & ~hold_IN & ~branch_taken_IN;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_instr_next     = r_instr;
        w_next_inst_next = r_next_inst;
        w_valid_next     = r_valid;
        if (hold_IN) begin
            w_state_next = r_state;
        end else if (branch_taken_IN) begin
            w_pc_next        = branch_target_IN;
            w_instr_next     = 32'd0;
            w_next_inst_next = '0;
            w_valid_next     = 1'b0;
            w_state_next     = ST_FLUSH;
        end else if (w_hazard) begin
            w_state_next = ST_STALL;
        end else begin
            w_pc_next        = w_pc_inc;
            w_instr_next     = instr_IN;
            w_next_inst_next = w_pc_inc;
            w_valid_next     = 1'b1;
            w_state_next     = ST_RUN;
        end
    end

    always_ff @(posedge clk_BF0) begin
        if (!rst_n_BF0) begin
            r_state     <= ST_FILL;
            r_pc        <= PC_W'(RESET_PC);
            r_instr     <= 32'd0;
            r_next_inst <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_instr     <= w_instr_next;
            r_next_inst <= w_next_inst_next;
            r_valid     <= w_valid_next;
        end
    end

    assign pc_BF0       = r_pc;
    assign instr_BF0    = r_instr;
    assign nextInst_BF0 = r_next_inst;
    assign valid_BF0    = r_valid;
    assign state_BF0    = r_state;

`ifdef BF0_STALL_COUNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_cnt_evt;

    assign w_cnt_evt = bubble_BF0 | (branch_taken_IN & ~hold_IN);

    always_ff @(posedge clk_BF0) begin
        if (!rst_n_BF0) begin
            r_stall_cnt <= 16'd0;
        end else if (w_cnt_evt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_BF0 = r_stall_cnt;
`endif

`ifndef SYNTHESIS
    // The bubble must have cleared MemRead in ID/EX, so a repeat hazard out of STALL is a bug upstream.
    always_ff @(posedge clk_BF0) begin
        if (rst_n_BF0 && (r_state == ST_STALL) && !hold_IN && !branch_taken_IN) begin
            assert (!w_hazard)
                else $error("bf0_fetch_hazard: consecutive load-use hazard in STALL");
        end
    end
`endif

endmodule

// File: tb/tb_bf0_fetch_hazard.sv
// Directed bench for bf0_fetch_hazard: fetch sequencing, load-use stall, flush, hold, reset, wrap.
module tb_bf0_fetch_hazard;

    logic        clk_BF0 = 1'b0;
    logic        rst_n_BF0;
    logic [31:0] instr_IN;
    logic        hold_IN;
    logic        branch_taken_IN;
    logic [7:0]  branch_target_IN;
    logic        idex_memread_IN;
    logic [4:0]  idex_rt_IN;
    logic [7:0]  pc_BF0;
    logic [31:0] instr_BF0;
    logic [7:0]  nextInst_BF0;
    logic        valid_BF0;
    logic        bubble_BF0;
    logic [1:0]  state_BF0;
`ifdef BF0_STALL_COUNT_EN
    logic [15:0] stall_cnt_BF0;
`endif

    logic        ovr_en;
    logic [31:0] ovr_word;
    int          n_total = 0;
    int          n_bad   = 0;

    localparam logic [31:0] ADD_W = 32'h00A53020;  // add $6,$5,$5
    localparam logic [31:0] LW_W  = 32'h8C850000;  // lw  $5,0($4)

    assign instr_IN = ovr_en ? ovr_word : {24'hA5A5A5, pc_BF0};

    always #5 clk_BF0 = ~clk_BF0;

    bf0_fetch_hazard #(.PC_W(8), .PC_INC(4), .RESET_PC(0)) dut (
        .clk_BF0          (clk_BF0),
        .rst_n_BF0        (rst_n_BF0),
        .instr_IN         (instr_IN),
        .hold_IN          (hold_IN),
        .branch_taken_IN  (branch_taken_IN),
        .branch_target_IN (branch_target_IN),
        .idex_memread_IN  (idex_memread_IN),
        .idex_rt_IN       (idex_rt_IN),
        .pc_BF0           (pc_BF0),
        .instr_BF0        (instr_BF0),
        .nextInst_BF0     (nextInst_BF0),
        .valid_BF0        (valid_BF0),
        .bubble_BF0       (bubble_BF0),
        .state_BF0        (state_BF0)
`ifdef BF0_STALL_COUNT_EN
        ,
        .stall_cnt_BF0    (stall_cnt_BF0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_BF0);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [7:0] pc, input logic [31:0] ins,
                          input logic [7:0] nx, input logic v, input logic [1:0] st);
        chk({tag, ".pc"},    32'(pc_BF0),       32'(pc));
        chk({tag, ".instr"}, instr_BF0,         ins);
        chk({tag, ".next"},  32'(nextInst_BF0), 32'(nx));
        chk({tag, ".valid"}, 32'(valid_BF0),    32'(v));
        chk({tag, ".state"}, 32'(state_BF0),    32'(st));
    endtask

    // Fetch a specific word at the current pc, leaving it in IF/ID.
    task automatic load_word(input logic [31:0] w);
        ovr_en   = 1'b1;
        ovr_word = w;
        tick();
        ovr_en   = 1'b0;
    endtask

    initial begin
        rst_n_BF0 = 1'b0; hold_IN = 1'b0; branch_taken_IN = 1'b0; branch_target_IN = 8'h00;
        idex_memread_IN = 1'b0; idex_rt_IN = 5'd0; ovr_en = 1'b0; ovr_word = 32'd0;
        tick(); tick();
        chk_if("reset", 8'h00, 32'd0, 8'h00, 1'b0, 2'd0);

        // Free run
        rst_n_BF0 = 1'b1;
        tick(); chk_if("run1", 8'h04, 32'hA5A5A500, 8'h04, 1'b1, 2'd1);
        tick(); chk_if("run2", 8'h08, 32'hA5A5A504, 8'h08, 1'b1, 2'd1);
        tick(); chk_if("run3", 8'h0C, 32'hA5A5A508, 8'h0C, 1'b1, 2'd1);

        // Load-use stall
        load_word(ADD_W);
        chk_if("lu_load", 8'h10, ADD_W, 8'h10, 1'b1, 2'd1);
        idex_memread_IN = 1'b1; idex_rt_IN = 5'd5; #1;
        chk("lu_bubble", 32'(bubble_BF0), 32'd1);
        tick();
        chk_if("lu_stall", 8'h10, ADD_W, 8'h10, 1'b1, 2'd2);
        idex_memread_IN = 1'b0; #1;
        chk("lu_bubble_clr", 32'(bubble_BF0), 32'd0);
        tick();
        chk_if("lu_resume", 8'h14, 32'hA5A5A510, 8'h14, 1'b1, 2'd1);

        // No false hazard
        load_word(ADD_W);
        idex_memread_IN = 1'b1; idex_rt_IN = 5'd0; #1;
        chk("nf_rt0", 32'(bubble_BF0), 32'd0);
        idex_memread_IN = 1'b0; idex_rt_IN = 5'd5; #1;
        chk("nf_nomr", 32'(bubble_BF0), 32'd0);
        load_word(LW_W);
        idex_memread_IN = 1'b1; idex_rt_IN = 5'd5; #1;
        chk("nf_lw", 32'(bubble_BF0), 32'd0);
        tick();
        chk_if("nf_adv", 8'h20, 32'hA5A5A51C, 8'h20, 1'b1, 2'd1);
        idex_memread_IN = 1'b0;

        // Branch during hazard
        load_word(ADD_W);
        idex_memread_IN = 1'b1; idex_rt_IN = 5'd5;
        branch_taken_IN = 1'b1; branch_target_IN = 8'h40; #1;
        chk("br_bubble", 32'(bubble_BF0), 32'd0);
        tick();
        chk_if("br_flush", 8'h40, 32'd0, 8'h00, 1'b0, 2'd3);
        branch_taken_IN = 1'b0; idex_memread_IN = 1'b0;
        tick();
        chk_if("br_refill", 8'h44, 32'hA5A5A540, 8'h44, 1'b1, 2'd1);

        // Hold for three edges
        hold_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_if("hold", 8'h44, 32'hA5A5A540, 8'h44, 1'b1, 2'd1);
        end
        hold_IN = 1'b0;

        // Reset during STALL
        load_word(ADD_W);
        idex_memread_IN = 1'b1; idex_rt_IN = 5'd5;
        tick();
        chk("rs_stall", 32'(state_BF0), 32'd2);
        rst_n_BF0 = 1'b0;
        tick();
        chk_if("rs_reset", 8'h00, 32'd0, 8'h00, 1'b0, 2'd0);
        idex_memread_IN = 1'b0; rst_n_BF0 = 1'b1;

        // PC wrap
        for (int i = 0; i < 63; i++) tick();
        chk("wrap_fc", 32'(pc_BF0), 32'h0000_00FC);
        tick();
        chk("wrap_pc", 32'(pc_BF0), 32'd0);
        chk("wrap_next", 32'(nextInst_BF0), 32'd0);
        chk("wrap_instr", instr_BF0, 32'hA5A5A5FC);

`ifdef BF0_STALL_COUNT_EN
        rst_n_BF0 = 1'b0; tick(); rst_n_BF0 = 1'b1;
        chk("cnt_reset", 32'(stall_cnt_BF0), 32'd0);
        for (int k = 0; k < 2; k++) begin
            load_word(ADD_W);
            idex_memread_IN = 1'b1; idex_rt_IN = 5'd5;
            tick();
            idex_memread_IN = 1'b0;
        end
        chk("cnt_two", 32'(stall_cnt_BF0), 32'd2);
        branch_taken_IN = 1'b1; branch_target_IN = 8'h80;
        tick();
        branch_taken_IN = 1'b0;
        chk("cnt_three", 32'(stall_cnt_BF0), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
